// File: rtl/game_pkg.sv
// Game-wide types and default formation size.
package game_pkg;
  localparam int unsigned DEF_COLS = 8;
  localparam int unsigned DEF_ROWS = 4;

  typedef enum logic [2:0] {
    IDLE,
    MARCH,
    CLEARED,
    LANDED
  } grid_state_t;
endpackage

// File: rtl/invader_grid_ctl_pkg.sv
// Bus widths and small helpers for the invader formation controller.
package invader_grid_ctl_pkg;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned CMP_W   = 13;
  localparam int unsigned SCORE_W = 16;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by every stage that draws or collides against the screen.
package vga_pkg;
  localparam int unsigned HOR_PIXELS = 640;
  localparam int unsigned VER_PIXELS = 480;
endpackage

// File: rtl/invader_grid_ctl_if.sv
// Player-side / draw-side signals of the invader formation controller.
interface invader_grid_ctl_if #(
  parameter int unsigned CELLS = 32
);
  import invader_grid_ctl_pkg::*;

  logic               game_start;
  logic [COORD_W-1:0] xpos_shoot;
  logic [COORD_W-1:0] bullet_y;
  logic               bullet_active;
  logic [COORD_W-1:0] grid_x;
  logic [COORD_W-1:0] grid_y;
  logic [CELLS-1:0]   alive;
  logic               bullet_hit;
  logic [SCORE_W-1:0] score;
  logic               wave_cleared;
  logic               invaders_landed;

  modport master (
    output game_start, xpos_shoot, bullet_y, bullet_active,
    input  grid_x, grid_y, alive, bullet_hit, score, wave_cleared, invaders_landed
  );

  modport slave (
    input  game_start, xpos_shoot, bullet_y, bullet_active,
    output grid_x, grid_y, alive, bullet_hit, score, wave_cleared, invaders_landed
  );
endinterface

// File: rtl/clk_divide.sv
// Free-running divider: one-cycle registered tick every CYCLES clocks.
module clk_divide #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_W'(CYCLES - 1));
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/invader_grid_ctl.sv
// Invader formation: alive bitmap, edge-reversing march and a one-cell-per-clock
// bullet collision scan feeding score and wave status.
module invader_grid_ctl
  import game_pkg::*;
  import vga_pkg::*;
  import invader_grid_ctl_pkg::*;
#(
  parameter int unsigned COLS          = DEF_COLS,
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned INV_W         = 32,
  parameter int unsigned INV_H         = 24,
  parameter int unsigned GAP_X         = 16,
  parameter int unsigned GAP_Y         = 16,
  parameter int unsigned START_X       = 64,
  parameter int unsigned START_Y       = 64,
  parameter int unsigned STEP_X        = 4,
  parameter int unsigned STEP_DOWN     = 16,
  parameter int unsigned MARCH_CYCLES  = 2_000_000,
  parameter int unsigned BULLET_WIDTH  = 32,
  parameter int unsigned BULLET_HEIGHT = 32,
  parameter int unsigned PLAYER_HEIGHT = 32
) (
  input  logic               clk,
  input  logic               rst,
  invader_grid_ctl_if.slave  bus
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PX    = INV_W + GAP_X;
  localparam int unsigned PY    = INV_H + GAP_Y;

  localparam logic [CMP_W-1:0] GRID_H = CMP_W'(ROWS * PY - GAP_Y);
  localparam logic [CMP_W-1:0] LAND_Y = CMP_W'(VER_PIXELS - PLAYER_HEIGHT);

  grid_state_t        state_q, state_d;
  logic [COORD_W-1:0] grid_x_q, grid_x_d;
  logic [COORD_W-1:0] grid_y_q, grid_y_d;
  logic [N-1:0]       alive_q, alive_d;
  logic               dir_left_q, dir_left_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               hit_lock_q, hit_lock_d;
  logic               bullet_hit_q, bullet_hit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               wave_cleared_q, wave_cleared_d;
  logic               landed_q, landed_d;

  logic               march_tick;
  logic [COLS-1:0]    col_alive;
  logic [CMP_W-1:0]   left_off, right_off;
  logic [CMP_W-1:0]   cell_x, cell_y;
  logic [CMP_W-1:0]   shot_x, shot_y;
  logic               hit;

  clk_divide #(.CYCLES(MARCH_CYCLES)) u_march_div (
    .clk  (clk),
    .rst  (rst),
    .tick (march_tick)
  );

  // Offsets of the leftmost / rightmost columns that still hold a live invader.
  always_comb begin
    col_alive = '0;
    left_off  = '0;
    right_off = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (alive_q[r*COLS + c]) col_alive[c] = 1'b1;
      end
    end
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (col_alive[c]) left_off = CMP_W'(c * PX);
    end
    for (int c = 0; c < int'(COLS); c++) begin
      if (col_alive[c]) right_off = CMP_W'(c * PX);
    end
  end

  // Bounding-box overlap between the bullet and the cell under the scan index.
  always_comb begin
    cell_x = CMP_W'(grid_x_q) + CMP_W'((32'(idx_q) % COLS) * PX);
    cell_y = CMP_W'(grid_y_q) + CMP_W'((32'(idx_q) / COLS) * PY);
    shot_x = CMP_W'(bus.xpos_shoot);
    shot_y = CMP_W'(bus.bullet_y);
    hit    = (state_q == MARCH) && bus.bullet_active && !hit_lock_q && alive_q[idx_q] &&
             (shot_x < cell_x + CMP_W'(INV_W)) &&
             (shot_x + CMP_W'(BULLET_WIDTH) > cell_x) &&
             (shot_y < cell_y + CMP_W'(INV_H)) &&
             (shot_y + CMP_W'(BULLET_HEIGHT) > cell_y);
  end

  always_comb begin
    state_d        = state_q;
    grid_x_d       = grid_x_q;
    grid_y_d       = grid_y_q;
    alive_d        = alive_q;
    dir_left_d     = dir_left_q;
    hit_lock_d     = hit_lock_q;
    bullet_hit_d   = 1'b0;
    score_d        = score_q;
    idx_d          = (march_tick || idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

    if (hit) begin
      alive_d[idx_q] = 1'b0;
      bullet_hit_d   = 1'b1;
      score_d        = sat_inc(score_q);
      hit_lock_d     = 1'b1;
    end else if (!bus.bullet_active) begin
      hit_lock_d = 1'b0;
    end

    // Edge reversal drops the formation instead of stepping sideways.
    if (state_q == MARCH && march_tick) begin
      if (!dir_left_q) begin
        if (CMP_W'(grid_x_q) + right_off + CMP_W'(INV_W + STEP_X) > CMP_W'(HOR_PIXELS)) begin
          grid_y_d   = grid_y_q + COORD_W'(STEP_DOWN);
          dir_left_d = 1'b1;
        end else begin
          grid_x_d = grid_x_q + COORD_W'(STEP_X);
        end
      end else begin
        if (CMP_W'(grid_x_q) + left_off < CMP_W'(STEP_X)) begin
          grid_y_d   = grid_y_q + COORD_W'(STEP_DOWN);
          dir_left_d = 1'b0;
        end else begin
          grid_x_d = grid_x_q - COORD_W'(STEP_X);
        end
      end
    end

    case (state_q)
      IDLE:    if (bus.game_start) state_d = MARCH;
      MARCH: begin
        if (alive_q == '0)                            state_d = CLEARED;
        else if (CMP_W'(grid_y_q) + GRID_H >= LAND_Y) state_d = LANDED;
      end
      default: ;
    endcase

    wave_cleared_d = wave_cleared_q | (state_d == CLEARED);
    landed_d       = landed_q | (state_d == LANDED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grid_x_q       <= COORD_W'(START_X);
      grid_y_q       <= COORD_W'(START_Y);
      alive_q        <= '1;
      dir_left_q     <= 1'b0;
      idx_q          <= '0;
      hit_lock_q     <= 1'b0;
      bullet_hit_q   <= 1'b0;
      score_q        <= '0;
      wave_cleared_q <= 1'b0;
      landed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      grid_x_q       <= grid_x_d;
      grid_y_q       <= grid_y_d;
      alive_q        <= alive_d;
      dir_left_q     <= dir_left_d;
      idx_q          <= idx_d;
      hit_lock_q     <= hit_lock_d;
      bullet_hit_q   <= bullet_hit_d;
      score_q        <= score_d;
      wave_cleared_q <= wave_cleared_d;
      landed_q       <= landed_d;
    end
  end

  assign bus.grid_x          = grid_x_q;
  assign bus.grid_y          = grid_y_q;
  assign bus.alive           = alive_q;
  assign bus.bullet_hit      = bullet_hit_q;
  assign bus.score           = score_q;
  assign bus.wave_cleared    = wave_cleared_q;
  assign bus.invaders_landed = landed_q;
endmodule

// File: tb/tb_invader_grid_ctl.sv
// Directed bench: a fast-marching instance for march/landing and a slow one for kills.
module tb_invader_grid_ctl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  invader_grid_ctl_if #(.CELLS(32)) ifa ();
  invader_grid_ctl_if #(.CELLS(32)) ifb ();

  invader_grid_ctl #(.MARCH_CYCLES(8))  u_dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  invader_grid_ctl #(.MARCH_CYCLES(64)) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pos(input int y, input int x);
    return {8'h00, 12'(y), 12'(x)};
  endfunction

  function automatic logic [31:0] pos_a();
    return {8'h00, ifa.grid_y, ifa.grid_x};
  endfunction

  function automatic logic [31:0] pos_b();
    return {8'h00, ifb.grid_y, ifb.grid_x};
  endfunction

  // Wait for the next formation move on instance A (bounded).
  task automatic wait_move_a(input string tag);
    logic [31:0] old;
    bit          moved;
    old   = pos_a();
    moved = 0;
    for (int k = 0; k < 20 && !moved; k++) begin
      @(negedge clk);
      if (pos_a() != old) moved = 1;
    end
    if (!moved) check(tag, 32'(moved), 32'd1);
  endtask

  // Track cell (r,c) of instance B with the bullet until it dies (bounded).
  task automatic kill_b(input int r, input int c, input int exp_score);
    bit got;
    got = 0;
    ifb.bullet_active = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 100 && !got; k++) begin
      ifb.xpos_shoot    = ifb.grid_x + 12'(c * 48);
      ifb.bullet_y      = ifb.grid_y + 12'(r * 40);
      ifb.bullet_active = 1'b1;
      @(negedge clk);
      if (ifb.bullet_hit) got = 1;
    end
    check("kill_hit", 32'(got), 32'd1);
    check("kill_alive_bit", 32'(ifb.alive[r*8 + c]), 32'd0);
    check("kill_score", 32'(ifb.score), 32'(exp_score));
  endtask

  initial begin
    int          hits;
    bit          got;
    int          sc;
    logic [31:0] frozen;

    ifa.game_start = 1'b0; ifa.xpos_shoot = '0; ifa.bullet_y = '0; ifa.bullet_active = 1'b0;
    ifb.game_start = 1'b0; ifb.xpos_shoot = '0; ifb.bullet_y = '0; ifb.bullet_active = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset values and idle behaviour.
    check("rst_pos_a", pos_a(), pos(64, 64));
    check("rst_alive_a", ifa.alive, 32'hFFFF_FFFF);
    check("rst_score_a", 32'(ifa.score), 32'd0);
    check("rst_hit_a", 32'(ifa.bullet_hit), 32'd0);
    check("rst_cleared_a", 32'(ifa.wave_cleared), 32'd0);
    check("rst_landed_a", 32'(ifa.invaders_landed), 32'd0);
    check("rst_pos_b", pos_b(), pos(64, 64));
    check("rst_alive_b", ifb.alive, 32'hFFFF_FFFF);
    repeat (50) @(negedge clk);
    check("idle_pos_a", pos_a(), pos(64, 64));
    check("idle_pos_b", pos_b(), pos(64, 64));

    // First kill on cell (0,0).
    ifb.game_start    = 1'b1;
    ifb.xpos_shoot    = 12'd70;
    ifb.bullet_y      = 12'd70;
    ifb.bullet_active = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ifb.bullet_hit) got = 1;
    end
    check("t2_hit", 32'(got), 32'd1);
    check("t2_alive", ifb.alive, 32'hFFFF_FFFE);
    check("t2_score", 32'(ifb.score), 32'd1);
    @(negedge clk);
    check("t2_pulse_width", 32'(ifb.bullet_hit), 32'd0);

    // Held bullet cannot kill twice; a fresh bullet on a dead cell does nothing.
    hits = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifb.bullet_hit) hits++;
    end
    check("t3_hold_hits", 32'(hits), 32'd0);
    ifb.bullet_active = 1'b0;
    repeat (2) @(negedge clk);
    ifb.bullet_active = 1'b1;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifb.bullet_hit) hits++;
    end
    check("t3_dead_cell_hits", 32'(hits), 32'd0);
    check("t3_score", 32'(ifb.score), 32'd1);

    // Kill column 7: rightmost live column is 6, reversal moves from x=272 to x=320.
    for (int r = 0; r < 4; r++) kill_b(r, 7, 2 + r);
    ifb.bullet_active = 1'b0;
    got = 0;
    for (int k = 0; k < 8000 && !got; k++) begin
      @(negedge clk);
      if (ifb.grid_y != 12'd64) got = 1;
    end
    check("t4_b_drop_seen", 32'(got), 32'd1);
    check("t4_b_drop_pos", pos_b(), pos(80, 320));
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (ifb.grid_x != 12'd320) got = 1;
    end
    check("t4_b_left_step", pos_b(), pos(80, 316));

    // Clear the wave.
    sc = 6;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 7; c++) begin
        if (r != 0 || c != 0) begin
          kill_b(r, c, sc);
          sc++;
        end
      end
    end
    ifb.bullet_active = 1'b0;
    check("t5_alive_empty", ifb.alive, 32'h0);
    @(negedge clk);
    check("t5_cleared", 32'(ifb.wave_cleared), 32'd1);
    check("t5_score", 32'(ifb.score), 32'd32);
    frozen = pos_b();
    ifb.bullet_active = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_frozen", pos_b(), frozen);
    check("t5_score_hold", 32'(ifb.score), 32'd32);
    check("t5_cleared_sticky", 32'(ifb.wave_cleared), 32'd1);
    check("t5_not_landed", 32'(ifb.invaders_landed), 32'd0);

    rst_b = 1'b1;
    @(negedge clk);
    check("t5_rst_pos", pos_b(), pos(64, 64));
    check("t5_rst_alive", ifb.alive, 32'hFFFF_FFFF);
    check("t5_rst_score", 32'(ifb.score), 32'd0);
    check("t5_rst_cleared", 32'(ifb.wave_cleared), 32'd0);
    check("t5_rst_hit", 32'(ifb.bullet_hit), 32'd0);
    rst_b = 1'b0;
    ifb.bullet_active = 1'b0;
    ifb.game_start    = 1'b0;

    // Free march on instance A: 52 right steps, drop at x=272, then step left.
    ifa.game_start = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      wait_move_a("t4_move_timeout");
      check("t4_step_right", pos_a(), pos(64, 64 + 4*k));
    end
    wait_move_a("t4_move_timeout");
    check("t4_drop", pos_a(), pos(80, 272));
    wait_move_a("t4_move_timeout");
    check("t4_step_left", pos_a(), pos(80, 268));

    // Landing after fifteen drops: bottom edge 304+144 reaches 448.
    got = 0;
    for (int k = 0; k < 12000 && !got; k++) begin
      @(negedge clk);
      if (ifa.invaders_landed) got = 1;
    end
    check("t6_landed", 32'(got), 32'd1);
    check("t6_land_pos", pos_a(), pos(304, 272));
    check("t6_not_cleared", 32'(ifa.wave_cleared), 32'd0);
    ifa.xpos_shoot    = 12'd272;
    ifa.bullet_y      = 12'd304;
    ifa.bullet_active = 1'b1;
    hits = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifa.bullet_hit) hits++;
    end
    check("t6_no_hits", 32'(hits), 32'd0);
    check("t6_alive", ifa.alive, 32'hFFFF_FFFF);
    check("t6_score", 32'(ifa.score), 32'd0);
    check("t6_frozen", pos_a(), pos(304, 272));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
